im_fetch_responder: RTL
=======================

Name: im_fetch_responder

Overview:
- Instruction-memory responder at the far end of the CPU fetch interface.
- Samples the fetch-side active-low chip enable, write enable, byte address and write data, and returns the instruction word after a configurable read latency.
- Raises a stall to the CPU while a multi-cycle read is outstanding; the CPU folds this into its bus-stall vector and holds the PC.
- Also serves program-load writes with per-byte masks.

Parameters:
ADDR_W, 16, byte-address width; word index = addr[ADDR_W-1:2]
DEPTH, 16384, number of 32-bit words; must satisfy DEPTH <= 2^(ADDR_W-2)
LAT, 1, read latency in cycles from acceptance edge to rvalid; legal range 1..15

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-low reset
ceb  input  1  chip enable, active low; request present when 0
web  input  1  write enable, active low; 0 = write, 1 = read
addr  input  ADDR_W  byte address; bits [1:0] ignored
wdata  input  32  write data
bweb  input  4  byte write enables, active low; bit i gates wdata[8i+7:8i]
rdata  output  32  read data; valid when rvalid=1, otherwise holds last value
rvalid  output  1  one-cycle pulse: rdata carries the response to the accepted read
rerr  output  1  pulses with rvalid when the read word index >= DEPTH
stall  output  1  1 while a read is outstanding and not yet returned

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, latency counter=0, rdata=0, rvalid=0, rerr=0, stall=0.
  - Memory contents are not cleared.
  - Reset during BUSY aborts the read; no rvalid is ever produced for it.
- FSM states: IDLE, BUSY.
- IDLE, ceb=0, web=1 (read accept at edge T0):
  - Latch the word index.
  - If LAT=1: rdata loaded from the array at T0 and visible in cycle T0+1 with rvalid=1; stay in IDLE; stall never asserts.
  - If LAT>1: go to BUSY, counter=LAT-1, stall=1.
- BUSY:
  - Counter decrements each edge.
  - At the edge where the counter reaches 0: rdata loaded, rvalid=1 for one cycle, stall=0, return to IDLE.
  - stall is 1 for exactly LAT-1 cycles (T0+1 .. T0+LAT-1); rvalid appears in cycle T0+LAT.
- IDLE, ceb=0, web=0 (write accept):
  - Bytes with bweb[i]=0 are written at that edge; bytes with bweb[i]=1 are preserved.
  - No rvalid, no stall; rdata holds.
- Requests while BUSY are ignored, not queued. The CPU is stalled and re-presents the request.
- A request in the same cycle that rvalid asserts (back in IDLE) is accepted normally. Back-to-back reads at LAT=1 therefore give one result per cycle.
- ceb=1: no action; rvalid=0 next cycle; rdata holds.
- Out of range (word index >= DEPTH):
  - Read returns rdata=0 with rerr=1 alongside rvalid.
  - Write is dropped; no error signalling on writes.
- Read-after-write: a read of the same word accepted the cycle after a write returns the new data.
- rvalid, rerr and rdata are registered outputs. stall is decoded from the state register only (no combinational path from inputs).

Decomposition:
- Package im_pkg:
  - typedef enum logic {IM_IDLE, IM_BUSY} im_state_t
  - localparam WORD_W=32, BYTES=4
  - function word_idx(addr)
- Sub-module im_mem_array: DEPTH x 32 synchronous single-port RAM with active-low byte write mask, one-cycle registered read. The responder wraps it with the FSM, counter, latency alignment and range check. For LAT>1, the read address is held and the array read is issued at the final BUSY edge.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, ceb=1 -> rdata=0, rvalid=0, stall=0, rerr=0; hold rst=1 for 5 idle cycles -> outputs unchanged.
- Write then read, LAT=1: write addr=0x0010, wdata=0xDEADBEEF, bweb=4'b0000; next cycle read addr=0x0010 -> following cycle rvalid=1, rdata=0xDEADBEEF, stall never 1.
- Byte mask: word 0x0010 = 0xDEADBEEF, write wdata=0x11223344, bweb=4'b1010; read 0x0010 -> rdata=0xDE22BE44.
- LAT=3 latency and stall: read addr=0x0010 accepted at T0 -> stall=1 in T0+1 and T0+2; rvalid=1 with data in T0+3, stall=0. A different address presented during BUSY is ignored, with no extra rvalid.
- Out of range (DEPTH=16, ADDR_W=16):
  - Read addr=0x0040 -> rvalid=1, rdata=0, rerr=1.
  - Write 0x0040 followed by read of word 0 -> word 0 unchanged.
- Reset mid-read (LAT=4): accept read, assert rst=0 at T0+2 -> stall=0, rvalid stays 0 through T0+6. A new read after release returns the correct data with normal latency.

Source files
------------

// File: rtl/im_pkg.sv
// Shared types and helpers for the instruction-memory fetch responder.
package im_pkg;

    typedef enum logic {
        IM_IDLE = 1'b0,
        IM_BUSY = 1'b1
    } im_state_t;

    localparam int WORD_W = 32;
    localparam int BYTES  = 4;

    // Byte address to 32-bit word index; the low two address bits select a byte lane only.
    function automatic logic [29:0] word_idx(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/im_mem_array.sv
// Purpose: DEPTH x 32 single-port synchronous RAM with active-low byte write mask.
// Latency: read data registered, valid the cycle after rd_en; writes land on the same edge.
// Backpressure: none; the caller never issues a read and a write together.
module im_mem_array
    import im_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic              wr_en,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BYTES-1:0]  bweb,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents survive reset so a program load is not lost across a CPU reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!bweb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_zero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/im_fetch_responder.sv
// Purpose: fetch-side instruction memory responder with program-load byte writes.
// Latency: rvalid LAT cycles after the accepting edge; stall high for the LAT-1 cycles between.
// Backpressure: requests seen while BUSY are dropped; the CPU holds on stall and re-presents.
module im_fetch_responder
    import im_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16384,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ceb,
    input  logic              web,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        bweb,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              rerr,
    output logic              stall
);

    localparam int          MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam logic [3:0]  LAT_M1    = 4'(LAT - 1);
    localparam bit          ONE_CYCLE = (LAT == 1);

    im_state_t         state;
    im_state_t         state_nxt;
    logic [3:0]        cnt;
    logic [MEM_AW-1:0] idx_q;
    logic              oor_q;

    logic [29:0]       idx_full;
    logic              oor_in;
    logic              rd_acc;
    logic              wr_acc;
    logic              last_beat;
    logic              rd_issue;
    logic              rd_zero;
    logic [MEM_AW-1:0] rd_idx;

    assign idx_full  = word_idx(32'(addr));
    assign oor_in    = (idx_full >= DEPTH_W);
    assign rd_acc    = (state == IM_IDLE) && !ceb && web;
    assign wr_acc    = (state == IM_IDLE) && !ceb && !web;
    assign last_beat = (state == IM_BUSY) && (cnt <= 4'd1);

    // Single-cycle reads hit the array on the accepting edge; longer ones on the final BUSY edge.
    assign rd_issue = ONE_CYCLE ? rd_acc : last_beat;
    assign rd_idx   = (state == IM_IDLE) ? idx_full[MEM_AW-1:0] : idx_q;
    assign rd_zero  = (state == IM_IDLE) ? oor_in : oor_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IM_IDLE: if (rd_acc && !ONE_CYCLE) state_nxt = IM_BUSY;
            IM_BUSY: if (last_beat)            state_nxt = IM_IDLE;
            default:                           state_nxt = IM_IDLE;
        endcase
    end

    always_comb begin
        stall = (state == IM_BUSY);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            idx_q <= '0;
            oor_q <= 1'b0;
        end else if (rd_acc && !ONE_CYCLE) begin
            cnt   <= LAT_M1;
            idx_q <= idx_full[MEM_AW-1:0];
            oor_q <= oor_in;
        end else if (state == IM_BUSY) begin
            cnt   <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rerr   <= 1'b0;
        end else begin
            rvalid <= rd_issue;
            rerr   <= rd_issue && rd_zero;
        end
    end

    // Out-of-range writes are dropped so they cannot alias onto a real word.
    im_mem_array #(
        .DEPTH (DEPTH),
        .AW    (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_issue),
        .rd_zero (rd_zero),
        .wr_en   (wr_acc && !oor_in),
        .idx     (rd_idx),
        .wdata   (wdata),
        .bweb    (bweb),
        .rdata   (rdata)
    );

endmodule
